stage1_seq: RTL



---
 rtl/stage1_pkg.sv | 15 +
 rtl/stage1_seq_if.sv | 29 ++
 rtl/stage1_dp.sv | 29 ++
 rtl/stage1_seq.sv | 101 ++++++++++
 4 files changed

// File: rtl/stage1_pkg.sv
// Shared types and width helpers for the stage-1 combiner controller and datapath.
package stage1_pkg;

    typedef enum logic [1:0] {
        IDLE,
        COMBINE,
        SERIAL
    } state_e;

    // Shift by up to n-1 lanes plus log2(n) bits of carry growth from the sum.
    function automatic int out_bit_width(input int n, input int bw);
        return bw + n - 1 + $clog2(n);
    endfunction

endpackage

// File: rtl/stage1_seq_if.sv
// Upstream vector handshake plus downstream word handshake of the stage-1 controller.
interface stage1_seq_if #(
    parameter int NUM_INPUTS = 4,
    parameter int BIT_WIDTH  = 8
);
    localparam int OUT_BIT_WIDTH = stage1_pkg::out_bit_width(NUM_INPUTS, BIT_WIDTH);
    localparam int CNT_W         = $clog2(NUM_INPUTS);

    logic                                 cfg_bypass;
    logic                                 in_valid;
    logic                                 in_ready;
    logic [NUM_INPUTS-1:0][BIT_WIDTH-1:0] in_data;
    logic                                 out_valid;
    logic                                 out_ready;
    logic [OUT_BIT_WIDTH-1:0]             out_data;
    logic [CNT_W-1:0]                     out_idx;
    logic                                 out_last;

    modport master (
        output cfg_bypass, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_idx, out_last
    );

    modport slave (
        input  cfg_bypass, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_idx, out_last
    );

endinterface

// File: rtl/stage1_dp.sv
// Stage-1 shift-add combiner datapath: signed sum of lane<<i, or one lane zero-extended.
module stage1_dp
    import stage1_pkg::*;
#(
    parameter int  NUM_INPUTS    = 4,
    parameter int  BIT_WIDTH     = 8,
    localparam int OUT_BIT_WIDTH = out_bit_width(NUM_INPUTS, BIT_WIDTH),
    localparam int CNT_W         = $clog2(NUM_INPUTS)
) (
    input  logic [NUM_INPUTS-1:0][BIT_WIDTH-1:0] data_in,
    input  logic                                 DISABLE_STAGE_1,
    input  logic [CNT_W-1:0]                     count,
    output logic [OUT_BIT_WIDTH-1:0]             data_out
);

    logic [OUT_BIT_WIDTH-1:0] acc;
    logic [OUT_BIT_WIDTH-1:0] lane;

    always_comb begin
        acc  = '0;
        lane = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            lane = {{(OUT_BIT_WIDTH-BIT_WIDTH){data_in[i][BIT_WIDTH-1]}}, data_in[i]};
            acc  = acc + (lane << i);
        end
        data_out = DISABLE_STAGE_1 ? OUT_BIT_WIDTH'(data_in[count]) : acc;
    end

endmodule

// File: rtl/stage1_seq.sv
// Sequencing controller for the stage-1 combiner: holds one input vector and walks the
// external datapath through a single combine word or NUM_INPUTS serial bypass words.
module stage1_seq
    import stage1_pkg::*;
#(
    parameter int  NUM_INPUTS    = 4,
    parameter int  BIT_WIDTH     = 8,
    localparam int OUT_BIT_WIDTH = out_bit_width(NUM_INPUTS, BIT_WIDTH),
    localparam int CNT_W         = $clog2(NUM_INPUTS)
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    stage1_seq_if.slave                          bus,
    output logic [NUM_INPUTS-1:0][BIT_WIDTH-1:0] s1_in,
    output logic                                 s1_disable,
    output logic [CNT_W-1:0]                     s1_count,
    input  logic [OUT_BIT_WIDTH-1:0]             s1_out
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_INPUTS - 1);

    state_e                               state_q, state_d;
    logic [CNT_W-1:0]                     idx_q, idx_d;
    logic                                 mode_q, mode_d;
    logic [NUM_INPUTS-1:0][BIT_WIDTH-1:0] vec_q, vec_d;
    logic                                 fire, accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            mode_q  <= 1'b0;
            vec_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            mode_q  <= mode_d;
            vec_q   <= vec_d;
        end
    end

    // Outputs decode straight from registered state so reset clears them asynchronously.
    always_comb begin
        bus.out_valid = 1'b0;
        bus.out_idx   = '0;
        bus.out_last  = 1'b0;
        s1_disable    = 1'b0;
        s1_count      = '0;
        case (state_q)
            COMBINE: begin
                bus.out_valid = 1'b1;
                bus.out_last  = 1'b1;
            end
            SERIAL: begin
                bus.out_valid = 1'b1;
                s1_disable    = mode_q;
                s1_count      = idx_q;
                bus.out_idx   = idx_q;
                bus.out_last  = (idx_q == LAST);
            end
            default: ;
        endcase
    end

    // Accepting while the last word leaves removes the IDLE bubble between vectors.
    assign fire         = bus.out_valid & bus.out_ready;
    assign bus.in_ready = (state_q == IDLE) | (fire & bus.out_last);
    assign accept       = bus.in_valid & bus.in_ready;
    assign s1_in        = vec_q;
    assign bus.out_data = s1_out;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        mode_d  = mode_q;
        vec_d   = vec_q;
        case (state_q)
            COMBINE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            SERIAL: begin
                if (bus.out_ready) begin
                    if (idx_q == LAST) begin
                        state_d = IDLE;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: ;
        endcase
        if (accept) begin
            vec_d   = bus.in_data;
            mode_d  = bus.cfg_bypass;
            idx_d   = '0;
            state_d = bus.cfg_bypass ? SERIAL : COMBINE;
        end
    end

endmodule
